// File: rtl/dzrbuf_pkg.sv
// dzrbuf_pkg: shared entry layout and scanner state encoding for the DZ11 receive path
package dzrbuf_pkg;
    localparam int ENTRY_W  = 15;
    localparam int OVRN_BIT = 14;
    localparam int FRME_BIT = 13;
    localparam int PARE_BIT = 12;
    localparam int LINE_LSB = 8;
    localparam int CHAR_LSB = 0;
    localparam int DVAL_BIT = 15;
    typedef enum logic [1:0] {SCAN, ACK, WAIT} scan_state_t;
endpackage

// File: rtl/dz_silo.sv
// dz_silo: synchronous receive FIFO; push into a full silo is accepted only alongside a pop
module dz_silo
    import dzrbuf_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ENTRY_W-1:0]         din,
    output logic [ENTRY_W-1:0]         dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic wr, rd;
    assign empty = count == '0;
    assign full  = count == (AW+1)'(DEPTH);
    assign rd    = pop & !empty;
    assign wr    = push & (!full | rd);
    assign dout  = mem[rp];
    // storage array, no reset needed since count guards visibility
    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= din;
    end
    // pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (rd) rp <= rp + 1'b1;
            count <= count + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
endmodule

// File: rtl/dz_rbuf.sv
// dz_rbuf: DZ11 receive scanner, silo, RBUF read-edge pop and silo alarm
module dz_rbuf
    import dzrbuf_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int SALVL = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        csrMSE,
    input  logic        csrSAE,
    input  logic        rbufREAD,
    input  logic        devLOBYTE,
    input  logic [7:0]  uartRXFULL,
    input  logic [63:0] uartRXDATA,
    input  logic [7:0]  uartRXFRME,
    input  logic [7:0]  uartRXPARE,
    output logic [7:0]  uartRXCLR,
    output logic        rbufRDONE,
    output logic        rbufSA,
    output logic [15:0] regRBUF
);
    logic                   srst, rd, rd_q, read_ev, push, pop_ok, push_ok, empty, full, ovrn, sa_q;
    logic [2:0]             scan;
    logic [4:0]             sa_cnt, sa_nx;
    logic [ENTRY_W-1:0]     din, dout;
    logic [$clog2(DEPTH):0] count;
    scan_state_t            state;
    assign srst    = rst | clr;
    assign rd      = rbufREAD & devLOBYTE;
    assign read_ev = rd & !rd_q;
    assign push    = (state == SCAN) & csrMSE & uartRXFULL[scan];
    assign pop_ok  = read_ev & !empty;
    assign push_ok = push & (!full | pop_ok);
    assign sa_nx   = read_ev ? '0 : push_ok ? (sa_cnt == '1 ? sa_cnt : sa_cnt + 1'b1) : sa_cnt;
    assign rbufRDONE = !empty;
    assign rbufSA    = sa_q & csrSAE;
    assign regRBUF   = empty ? '0 : {1'b1, dout};
    // assemble the silo entry for the line currently under the scan pointer
    always_comb begin
        din                  = '0;
        din[OVRN_BIT]        = ovrn;
        din[FRME_BIT]        = uartRXFRME[scan];
        din[PARE_BIT]        = uartRXPARE[scan];
        din[LINE_LSB +: 3]   = scan;
        din[CHAR_LSB +: 8]   = uartRXDATA[{scan, 3'b000} +: 8];
    end
    dz_silo #(.DEPTH(DEPTH)) silo (
        .clk   (clk),
        .rst   (srst),
        .push  (push),
        .pop   (pop_ok),
        .din   (din),
        .dout  (dout),
        .count (count),
        .empty (empty),
        .full  (full)
    );
    // round-robin scanner; ACK then WAIT gives the UART time to drop RXFULL
    always_ff @(posedge clk) begin
        if (srst) begin
            state     <= SCAN;
            scan      <= '0;
            uartRXCLR <= '0;
        end else begin
            uartRXCLR <= '0;
            case (state)
                SCAN: if (csrMSE) begin
                    if (uartRXFULL[scan]) begin
                        uartRXCLR <= 8'(1) << scan;
                        state     <= ACK;
                    end else scan <= scan + 1'b1;
                end
                ACK:  state <= WAIT;
                WAIT: begin
                    scan  <= scan + 1'b1;
                    state <= SCAN;
                end
                default: state <= SCAN;
            endcase
        end
    end
    // read strobe edge detect, overrun memory and silo alarm tracking
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_q   <= 1'b0;
            ovrn   <= 1'b0;
            sa_cnt <= '0;
            sa_q   <= 1'b0;
        end else begin
            rd_q   <= rd;
            ovrn   <= push_ok ? 1'b0 : (push | ovrn);
            sa_cnt <= sa_nx;
            sa_q   <= read_ev ? 1'b0 : (sa_q | (csrSAE & (sa_nx >= 5'(SALVL))));
        end
    end
endmodule
